// File: rtl/instr_fetch.sv
// Instruction fetch: reads one word at PC and splits it into opcode/rd/rs1/rs2. Optional HALT support under FETCH_HALT_EN.
// Latency: ack-to-valid 1 cycle, transfer-to-next-request 1 cycle; at most one read outstanding.
// Backpressure: the decoded fields hold while instr_valid && !instr_ready, and no new request is issued meanwhile.
module instr_fetch #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_pc,
    input  logic [PC_W-1:0]    load_addr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [2:0]         opcode,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, PRESENT, HALTED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [11:0]     fields;
    logic            is_halt;

    assign is_halt = HALT_EN && (fields[11:9] == 3'b111);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (imem_ack) state_nxt = PRESENT;
            PRESENT: if (instr_ready) state_nxt = is_halt ? HALTED : REQ;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            REQ:     imem_req    = 1'b1;
            PRESENT: instr_valid = 1'b1;
            HALTED:  halted      = HALT_EN;
            default: ;
        endcase
    end

    // Only the top 12 bits carry decoded fields; the rest of the word is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            fields   <= '0;
            instr_pc <= '0;
        end else if (state == IDLE) begin
            if (load_pc) pc <= load_addr;
        end else if ((state == REQ) && imem_ack) begin
            fields   <= imem_rdata[INSTR_W-1 -: 12];
            instr_pc <= pc;
            pc       <= pc + PC_W'(1);
        end
    end

    generate
        if (INSTR_W > 12) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^imem_rdata[INSTR_W-13:0];
        end
    endgenerate

    assign imem_addr = pc;
    assign opcode    = fields[11:9];
    assign rd        = fields[8:6];
    assign rs1       = fields[5:3];
    assign rs2       = fields[2:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_pc;
    logic [7:0]  load_addr;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  opcode, rd, rs1, rs2;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic [11:0] dut_fields;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.PC_W(8), .INSTR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .load_pc(load_pc), .load_addr(load_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
    );

    assign dut_fields = {opcode, rd, rs1, rs2};

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] rdata;
        logic [2:0]  op, f_rd, f_rs1, f_rs2;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; load_pc = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic begin_fetch(input logic [7:0] addr);
        load_pc = 1'b1; load_addr = addr; start = 1'b1;
        tick();
        load_pc = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [7:0]  exp_pc;
        logic [15:0] w;
        int          waitc;
        int          hold;

        vecs[0] = '{8'h10, 16'h2A40, 3'd1, 3'd2, 3'd4, 3'd4};
        vecs[1] = '{8'h00, 16'hFFFF, 3'd7, 3'd7, 3'd7, 3'd7};
        vecs[2] = '{8'h5A, 16'h0000, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[3] = '{8'h33, 16'h5397, 3'd2, 3'd4, 3'd7, 3'd1};
        vecs[4] = '{8'hFF, 16'hE000, 3'd7, 3'd0, 3'd0, 3'd0};
        vecs[5] = '{8'h80, 16'h1C70, 3'd0, 3'd7, 3'd0, 3'd7};

        // Reset values, with a spurious ack during reset and the cycle after.
        reset = 1'b1; start = 1'b0; load_pc = 1'b0; load_addr = 8'h00;
        imem_ack = 1'b1; imem_rdata = 16'hFFFF; instr_ready = 1'b1;
        tick();
        tick();
        chk("reset_state", {imem_req, instr_valid, halted, imem_addr, dut_fields, instr_pc},
            {3'b000, 8'h00, 12'h000, 8'h00});
        reset = 1'b0;
        tick();
        chk("ack_after_reset", {imem_req, instr_valid, dut_fields, instr_pc}, {2'b00, 12'h000, 8'h00});
        imem_ack = 1'b0; instr_ready = 1'b0;

        foreach (vecs[i]) begin
            do_reset();
            begin_fetch(vecs[i].addr);
            chk("vec_req", {imem_req, instr_valid, imem_addr}, {2'b10, vecs[i].addr});
            imem_ack = 1'b1; imem_rdata = vecs[i].rdata;
            tick();
            imem_ack = 1'b0;
            chk("vec_fields", {instr_valid, imem_req, opcode, rd, rs1, rs2},
                {2'b10, vecs[i].op, vecs[i].f_rd, vecs[i].f_rs1, vecs[i].f_rs2});
            chk("vec_instr_pc", instr_pc, vecs[i].addr);
        end

        // Load and start together, ack two cycles later, then backpressure.
        do_reset();
        begin_fetch(8'h10);
        chk("t31_req", {imem_req, imem_addr}, {1'b1, 8'h10});
        tick();
        chk("t31_wait", {imem_req, instr_valid, imem_addr}, {2'b10, 8'h10});
        imem_ack = 1'b1; imem_rdata = 16'h2A40;
        tick();
        imem_ack = 1'b0;
        chk("t31_fields", {instr_valid, opcode, rd, rs1, rs2}, {1'b1, 3'b001, 3'b010, 3'b100, 3'b100});
        chk("t31_instr_pc", instr_pc, 8'h10);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t32_hold", {instr_valid, imem_req, dut_fields, instr_pc}, {2'b10, 12'h2A4, 8'h10});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t32_next_req", {imem_req, instr_valid, imem_addr}, {2'b10, 8'h11});
        load_pc = 1'b1; load_addr = 8'h77; start = 1'b1;
        tick();
        load_pc = 1'b0; start = 1'b0;
        chk("load_ignored_in_req", {imem_req, imem_addr}, {1'b1, 8'h11});
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        tick();
        imem_ack = 1'b0;
        chk("load_ignored_pc", instr_pc, 8'h11);

        // PC wrap from all-ones.
        do_reset();
        begin_fetch(8'hFF);
        imem_ack = 1'b1; imem_rdata = 16'h1C70;
        tick();
        imem_ack = 1'b0;
        chk("wrap_instr_pc", instr_pc, 8'hFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_next_addr", {imem_req, imem_addr}, {1'b1, 8'h00});

        // Reset during a request that is being acknowledged.
        do_reset();
        begin_fetch(8'h40);
        imem_ack = 1'b1; imem_rdata = 16'h2A40; reset = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b0;
        chk("reset_mid_req", {instr_valid, imem_req, imem_addr, dut_fields, instr_pc},
            {2'b00, 8'h00, 12'h000, 8'h00});
        tick();
        chk("reset_mid_req_idle", {instr_valid, imem_req}, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset_mid_req_pc0", {imem_req, imem_addr}, {1'b1, 8'h00});

        // Back-to-back: ack and ready held high.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_req", {imem_req, instr_valid, imem_addr}, {2'b10, 8'(i)});
            imem_rdata = 16'h0100 * 16'(i);
            tick();
            chk("b2b_present", {instr_valid, imem_req, instr_pc}, {2'b10, 8'(i)});
            tick();
        end
        imem_ack = 1'b0; instr_ready = 1'b0;

`ifdef FETCH_HALT_EN
        do_reset();
        begin_fetch(8'h20);
        imem_ack = 1'b1; imem_rdata = 16'hE000;
        tick();
        imem_ack = 1'b0;
        chk("halt_presented", {instr_valid, opcode, halted}, {1'b1, 3'b111, 1'b0});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("halt_set", {halted, imem_req, instr_valid}, 3'b100);
        for (int k = 0; k < 20; k++) begin
            start = 1'b1; load_pc = 1'b1; load_addr = 8'h55;
            tick();
            chk("halt_hold", {halted, imem_req, instr_valid}, 3'b100);
        end
        start = 1'b0; load_pc = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_reset", {halted, imem_req, instr_valid, imem_addr}, {3'b000, 8'h00});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_restart", {halted, imem_req, imem_addr}, {2'b01, 8'h00});
`else
        do_reset();
        begin_fetch(8'h30);
        imem_ack = 1'b1; imem_rdata = 16'hE000;
        tick();
        imem_ack = 1'b0;
        chk("op7_presented", {instr_valid, opcode, halted}, {1'b1, 3'b111, 1'b0});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("op7_continues", {halted, imem_req, instr_valid, imem_addr}, {3'b010, 8'h31});
`endif

        // Randomized run: model tracks the expected fetch address and the word in flight.
        do_reset();
        exp_pc = 8'($urandom_range(0, 255));
        begin_fetch(exp_pc);
        for (int n = 0; n < 40; n++) begin
            chk("rnd_req", {imem_req, instr_valid, imem_addr}, {2'b10, exp_pc});
            waitc = $urandom_range(0, 3);
            for (int k = 0; k < waitc; k++) begin
                imem_ack = 1'b0; imem_rdata = 16'($urandom);
                load_pc = 1'($urandom); start = 1'($urandom); load_addr = 8'($urandom);
                tick();
                chk("rnd_wait", {imem_req, instr_valid, imem_addr}, {2'b10, exp_pc});
            end
            load_pc = 1'b0; start = 1'b0;
            w = 16'($urandom);
`ifdef FETCH_HALT_EN
            if (w[15:13] == 3'b111) w[15] = 1'b0;
`endif
            imem_ack = 1'b1; imem_rdata = w;
            tick();
            chk("rnd_present", {instr_valid, imem_req, dut_fields, instr_pc}, {2'b10, w[15:4], exp_pc});
            exp_pc = exp_pc + 8'd1;
            hold = $urandom_range(0, 2);
            instr_ready = 1'b0;
            for (int k = 0; k < hold; k++) begin
                imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
                tick();
                chk("rnd_hold", {instr_valid, imem_req, dut_fields}, {2'b10, w[15:4]});
            end
            imem_ack = 1'b0; instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
